fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_unit_insn.sv | 56 +++++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// fetch_unit_pkg: access-size encodings, burst length helper and fetch FSM states.
package fetch_unit_pkg;

  localparam logic [1:0] SIZE_1W  = 2'b00;
  localparam logic [1:0] SIZE_4W  = 2'b01;
  localparam logic [1:0] SIZE_8W  = 2'b10;
  localparam logic [1:0] SIZE_16W = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RECV  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic logic [4:0] burst_words(input logic [1:0] size);
    case (size)
      SIZE_1W: burst_words = 5'd1;
      SIZE_4W: burst_words = 5'd4;
      SIZE_8W: burst_words = 5'd8;
      default: burst_words = 5'd16;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_insn.sv
`default_nettype none
// insn_fifo: circular buffer of {pc, word} entries; flush empties it and overrides push/pop.
module insn_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [31:0]            push_pc,
  input  logic [31:0]            push_word,
  input  logic                   pop,
  input  logic                   flush,
  output logic [31:0]            head_pc,
  output logic [31:0]            head_word,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [31:0]  pc_mem   [DEPTH];
  logic [31:0]  word_mem [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      pc_mem[wr_ptr[AW-1:0]]   <= push_pc;
      word_mem[wr_ptr[AW-1:0]] <= push_word;
    end
  end

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign head_pc   = pc_mem[rd_ptr[AW-1:0]];
  assign head_word = word_mem[rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: burst instruction prefetcher feeding a FIFO, with redirect and in-flight drain.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int BUF_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [1:0]  burst_size,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic [1:0]  mem_access_size,
  output logic        mem_rw,
  output logic        mem_enable,
  input  logic        mem_busy,
  input  logic [31:0] mem_data_out,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic        fetch_busy
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  state_t        state;
  state_t        state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   recv_pc;
  logic [4:0]    word_cnt;
  logic [4:0]    n_words;
  logic          last_word;
  logic          room;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [31:0]   head_pc;
  logic [31:0]   head_word;

  assign n_words   = burst_words(burst_size);
  assign last_word = (word_cnt == 5'd1);
  assign room      = (CW'(BUF_DEPTH) - fifo_count) >= CW'(n_words);

  always_comb begin
    state_next = state;
    req_fire   = 1'b0;
    push       = 1'b0;
    case (state)
      ST_IDLE: if (run) state_next = ST_REQ;
      ST_REQ: begin
        if (!run) begin
          state_next = ST_IDLE;
        end else if (!mem_busy && room) begin
          req_fire   = 1'b1;
          state_next = ST_RECV;
        end
      end
      ST_RECV: begin
        push = 1'b1;
        if (last_word) state_next = ST_REQ;
      end
      ST_DRAIN: if (last_word) state_next = run ? ST_REQ : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // A request issued alongside a redirect still returns words, so they must be drained.
    if (redirect) begin
      push = 1'b0;
      if (req_fire)
        state_next = ST_DRAIN;
      else if (state == ST_RECV)
        state_next = last_word ? ST_REQ : ST_DRAIN;
      else if (state != ST_DRAIN)
        state_next = ST_REQ;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      fetch_pc <= '0;
      recv_pc  <= '0;
      word_cnt <= '0;
    end else begin
      state <= state_next;
      if (req_fire) begin
        recv_pc  <= fetch_pc;
        word_cnt <= n_words;
      end else if (state == ST_RECV || state == ST_DRAIN) begin
        recv_pc  <= recv_pc + 32'd4;
        word_cnt <= word_cnt - 5'd1;
      end
      if (redirect)
        fetch_pc <= redirect_pc & ~32'd3;
      else if (state == ST_RECV && last_word)
        fetch_pc <= recv_pc + 32'd4;
    end
  end

  assign pop = insn_valid & insn_ready & ~redirect;

  insn_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_insn_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_pc  (recv_pc),
    .push_word(mem_data_out),
    .pop      (pop),
    .flush    (redirect),
    .head_pc  (head_pc),
    .head_word(head_word),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign mem_enable      = req_fire;
  assign mem_address     = req_fire ? fetch_pc : 32'd0;
  assign mem_access_size = req_fire ? burst_size : 2'b00;
  assign mem_rw          = 1'b0;
  assign mem_data_in     = 32'd0;
  assign insn_valid      = ~fifo_empty;
  assign insn            = insn_valid ? head_word : 32'd0;
  assign insn_pc         = insn_valid ? head_pc : 32'd0;
  assign fetch_busy      = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: memory model queues expected {pc, word} as words are returned; consumer pops and compares.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  burst_size;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_rw;
  logic        mem_enable;
  logic        mem_busy;
  logic [31:0] mem_data_out;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic        fetch_busy;

  fetch_unit #(.BUF_DEPTH(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .run            (run),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .burst_size     (burst_size),
    .mem_address    (mem_address),
    .mem_data_in    (mem_data_in),
    .mem_access_size(mem_access_size),
    .mem_rw         (mem_rw),
    .mem_enable     (mem_enable),
    .mem_busy       (mem_busy),
    .mem_data_out   (mem_data_out),
    .insn           (insn),
    .insn_pc        (insn_pc),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .fetch_busy     (fetch_busy)
  );

  always #5 clock = ~clock;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  logic [63:0] exp_q[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] pop_log[$];
  logic [31:0] m_addr;
  logic [31:0] bus_pc;
  int          m_left = 0;
  bit          m_on_bus = 0;
  bit          m_drain = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a == 32'h100) ? 32'h8C010004 : (a ^ 32'hC0DE0000);
  endfunction

  function automatic int nwords(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 16;
    endcase
  endfunction

  // Memory model, scoreboard producer and consumer checker in one process for a fixed order.
  initial begin
    logic [63:0] e;
    mem_data_out = 32'd0;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        m_left   = 0;
        m_on_bus = 0;
        m_drain  = 0;
      end else begin
        if (insn_valid && insn_ready && !redirect) begin
          total_cnt++;
          if (exp_q.size() == 0) begin
            $display("FAIL pop_unexpected: got pc=%h insn=%h, required no valid word", insn_pc, insn);
          end else begin
            e = exp_q.pop_front();
            if ({insn_pc, insn} !== e)
              $display("FAIL pop_data: got pc=%h insn=%h, required pc=%h insn=%h",
                       insn_pc, insn, e[63:32], e[31:0]);
            else
              pass_cnt++;
          end
          pop_log.push_back(insn_pc);
        end
        if (m_on_bus && !m_drain && !redirect)
          exp_q.push_back({bus_pc, mem_data_out});
        if (redirect) begin
          exp_q.delete();
          m_drain = 1;
        end
        if (mem_enable) begin
          req_log.push_back(mem_address);
          req_cyc.push_back(cyc);
          m_addr  = mem_address;
          m_left  = nwords(mem_access_size);
          m_drain = redirect;
        end
      end
      @(posedge clock);
      #1;
      if (m_left != 0 && !reset) begin
        bus_pc       = m_addr;
        mem_data_out = memword(m_addr);
        m_on_bus     = 1;
        m_addr       = m_addr + 32'd4;
        m_left--;
      end else begin
        m_on_bus     = 0;
        mem_data_out = 32'd0;
        if (reset) m_left = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_pc = pc;
    redirect    = 1'b1;
    tick();
    redirect    = 1'b0;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    run         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    burst_size  = 2'b00;
    insn_ready  = 1'b0;
    mem_busy    = 1'b0;
    tick();
    tick();
    req_log.delete();
    req_cyc.delete();
    pop_log.delete();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_reqs(input int n, input string name);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      done = (req_log.size() >= n);
    end
    total_cnt++;
    if (!done) $display("FAIL %s_req_wait: got %0d requests, required %0d", name, req_log.size(), n);
    else pass_cnt++;
  endtask

  task automatic wait_done(input string name);
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      done = !fetch_busy && (exp_q.size() == 0);
    end
    total_cnt++;
    if (!done)
      $display("FAIL %s_drain: fetch_busy=%0b pending=%0d, required 0 and 0", name, fetch_busy, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    tick();
    @(negedge clock);
    total_cnt++;
    if ({mem_enable, mem_rw, mem_access_size, insn_valid, fetch_busy} !== 6'd0)
      $display("FAIL reset_ctrl: got %b, required 000000",
               {mem_enable, mem_rw, mem_access_size, insn_valid, fetch_busy});
    else pass_cnt++;
    total_cnt++;
    if ({mem_address, mem_data_in} !== 64'd0)
      $display("FAIL reset_mem_bus: got addr=%h data=%h, required 0", mem_address, mem_data_in);
    else pass_cnt++;
    total_cnt++;
    if ({insn, insn_pc} !== 64'd0)
      $display("FAIL reset_insn: got insn=%h pc=%h, required 0", insn, insn_pc);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    @(negedge clock);
    total_cnt++;
    if (fetch_busy !== 1'b0 || mem_enable !== 1'b0 || req_log.size() != 0)
      $display("FAIL idle_after_reset: got busy=%0b en=%0b reqs=%0d, required 0 0 0",
               fetch_busy, mem_enable, req_log.size());
    else pass_cnt++;
  endtask

  task automatic test_single();
    bit seen = 0;
    do_reset();
    burst_size = 2'b00;
    run        = 1'b1;
    pulse_redirect(32'h100);
    tick();
    run = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = insn_valid;
    end
    @(negedge clock);
    total_cnt++;
    if (insn_valid !== 1'b1 || insn !== 32'h8C010004 || insn_pc !== 32'h100)
      $display("FAIL single_word: got valid=%0b insn=%h pc=%h, required 1 8c010004 00000100",
               insn_valid, insn, insn_pc);
    else pass_cnt++;
    tick();
    insn_ready = 1'b1;
    wait_done("single");
    total_cnt++;
    if (req_log.size() != 1 || req_log[0] !== 32'h100)
      $display("FAIL single_req: got %0d requests first=%h, required 1 at 00000100",
               req_log.size(), (req_log.size() > 0) ? req_log[0] : 32'hX);
    else pass_cnt++;
  endtask

  task automatic test_burst4();
    do_reset();
    burst_size = 2'b01;
    insn_ready = 1'b1;
    run        = 1'b1;
    pulse_redirect(32'h200);
    wait_reqs(2, "burst4");
    run = 1'b0;
    wait_done("burst4");
    total_cnt++;
    if (req_log[0] !== 32'h200 || req_log[1] !== 32'h210)
      $display("FAIL burst4_req_addr: got %h %h, required 00000200 00000210", req_log[0], req_log[1]);
    else pass_cnt++;
    total_cnt++;
    if (pop_log.size() != 8 || pop_log[0] !== 32'h200 || pop_log[1] !== 32'h204 ||
        pop_log[2] !== 32'h208 || pop_log[3] !== 32'h20C)
      $display("FAIL burst4_order: got %0d pops first=%h, required 8 pops from 00000200",
               pop_log.size(), (pop_log.size() > 0) ? pop_log[0] : 32'hX);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    burst_size = 2'b11;
    insn_ready = 1'b0;
    run        = 1'b1;
    pulse_redirect(32'h1000);
    for (int i = 0; i < 40; i++) tick();
    total_cnt++;
    if (req_log.size() != 1 || insn_valid !== 1'b1)
      $display("FAIL bp_full: got reqs=%0d valid=%0b, required 1 1", req_log.size(), insn_valid);
    else pass_cnt++;
    insn_ready = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    insn_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total_cnt++;
    if (req_log.size() != 1)
      $display("FAIL bp_one_slot_left: got %0d requests, required 1", req_log.size());
    else pass_cnt++;
    insn_ready = 1'b1;
    wait_reqs(2, "bp");
    run = 1'b0;
    total_cnt++;
    if (req_log[1] !== 32'h1040)
      $display("FAIL bp_next_addr: got %h, required 00001040", req_log[1]);
    else pass_cnt++;
    wait_done("bp");
  endtask

  task automatic test_redirect_drain();
    do_reset();
    burst_size = 2'b10;
    insn_ready = 1'b1;
    run        = 1'b1;
    pulse_redirect(32'h300);
    tick();
    tick();
    tick();
    pulse_redirect(32'h400);
    @(negedge clock);
    total_cnt++;
    if (insn_valid !== 1'b0)
      $display("FAIL redirect_flush: got insn_valid=%0b, required 0", insn_valid);
    else pass_cnt++;
    wait_reqs(2, "redirect");
    run = 1'b0;
    wait_done("redirect");
    total_cnt++;
    if (req_log[1] !== 32'h400 || (req_cyc[1] - req_cyc[0]) != 9)
      $display("FAIL redirect_next_req: got addr=%h gap=%0d, required 00000400 gap 9",
               req_log[1], req_cyc[1] - req_cyc[0]);
    else pass_cnt++;
    total_cnt++;
    if (pop_log.size() != 9 || pop_log[0] !== 32'h300 || pop_log[1] !== 32'h400)
      $display("FAIL redirect_pops: got %0d pops second=%h, required 9 second=00000400",
               pop_log.size(), (pop_log.size() > 1) ? pop_log[1] : 32'hX);
    else pass_cnt++;
  endtask

  task automatic test_mem_busy();
    bit early = 0;
    do_reset();
    burst_size = 2'b00;
    insn_ready = 1'b1;
    mem_busy   = 1'b1;
    run        = 1'b1;
    pulse_redirect(32'h500);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (mem_enable !== 1'b0) early = 1;
      tick();
    end
    total_cnt++;
    if (early) $display("FAIL busy_hold: got mem_enable=1 while busy, required 0");
    else pass_cnt++;
    mem_busy = 1'b0;
    @(negedge clock);
    total_cnt++;
    if (mem_enable !== 1'b1 || mem_address !== 32'h500 || mem_access_size !== 2'b00)
      $display("FAIL busy_release: got en=%0b addr=%h size=%b, required 1 00000500 00",
               mem_enable, mem_address, mem_access_size);
    else pass_cnt++;
    tick();
    run = 1'b0;
    wait_done("busy");
  endtask

  task automatic test_wrap_and_reset();
    int nreq;
    do_reset();
    burst_size = 2'b01;
    insn_ready = 1'b1;
    run        = 1'b1;
    pulse_redirect(32'hFFFFFFF8);
    wait_reqs(2, "wrap");
    run = 1'b0;
    wait_done("wrap");
    total_cnt++;
    if (pop_log.size() < 4 || pop_log[0] !== 32'hFFFFFFF8 || pop_log[1] !== 32'hFFFFFFFC ||
        pop_log[2] !== 32'h0 || pop_log[3] !== 32'h4)
      $display("FAIL wrap_pcs: got %0d pops third=%h, required f8 fc 0 4",
               pop_log.size(), (pop_log.size() > 2) ? pop_log[2] : 32'hX);
    else pass_cnt++;
    total_cnt++;
    if (req_log[1] !== 32'h8)
      $display("FAIL wrap_next_addr: got %h, required 00000008", req_log[1]);
    else pass_cnt++;

    burst_size = 2'b10;
    insn_ready = 1'b0;
    run        = 1'b1;
    pulse_redirect(32'h600);
    tick();
    tick();
    tick();
    total_cnt++;
    if (insn_valid !== 1'b1 || fetch_busy !== 1'b1)
      $display("FAIL midburst_pre: got valid=%0b busy=%0b, required 1 1", insn_valid, fetch_busy);
    else pass_cnt++;
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({insn_valid, fetch_busy, mem_enable, mem_rw, mem_access_size} !== 6'd0 ||
        {insn, insn_pc, mem_address, mem_data_in} !== 128'd0)
      $display("FAIL midburst_reset: got valid=%0b busy=%0b insn=%h pc=%h, required all 0",
               insn_valid, fetch_busy, insn, insn_pc);
    else pass_cnt++;
    run = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    nreq  = req_log.size();
    for (int i = 0; i < 12; i++) tick();
    total_cnt++;
    if (insn_valid !== 1'b0 || fetch_busy !== 1'b0 || req_log.size() != nreq)
      $display("FAIL post_reset_idle: got valid=%0b busy=%0b new_reqs=%0d, required 0 0 0",
               insn_valid, fetch_busy, req_log.size() - nreq);
    else pass_cnt++;
  endtask

  initial begin
    reset       = 1'b1;
    run         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    burst_size  = 2'b00;
    insn_ready  = 1'b0;
    mem_busy    = 1'b0;
    test_reset();
    test_single();
    test_burst4();
    test_backpressure();
    test_redirect_drain();
    test_mem_busy();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
